// File: rtl/pattern_ctrl_pkg.sv
// Shared definitions for the programmable serial bit-pattern recognizer.
// Holds the run-controller state encoding used by pattern_match_ctrl.
package pattern_ctrl_pkg;

  // IDLE: waiting for configuration or start
  // FILL: priming the window with the first PAT_W-1 bits of a run
  // RUN : every accepted bit is compared against the pattern
  // DONE: one-cycle state that carries the done pulse back to IDLE
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } pm_state_t;

endpackage

// File: rtl/pattern_match_ctrl_if.sv
// Bus bundle between the serial front end / host and the pattern run controller.
// Signals:
//   cfg_load, cfg_pattern   pattern load request and value (MSB = oldest bit)
//   start, stop, run_len    run control; run_len = 0 means unlimited
//   serial_in, serial_valid serial data bit and its qualifier
//   busy                    high while a run is filling or running
//   match_pulse             one-cycle pulse per detected match
//   match_count, count_sat  match counter and its sticky saturation flag
//   done                    one-cycle pulse at the end of a length-limited run
// Modports: master drives the requests and data, slave is the controller.
interface pattern_match_ctrl_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8,
  parameter int LEN_W = 8
);

  logic             cfg_load;
  logic [PAT_W-1:0] cfg_pattern;
  logic             start;
  logic             stop;
  logic [LEN_W-1:0] run_len;
  logic             serial_in;
  logic             serial_valid;
  logic             busy;
  logic             match_pulse;
  logic [CNT_W-1:0] match_count;
  logic             count_sat;
  logic             done;

  modport master (
    output cfg_load, cfg_pattern, start, stop, run_len, serial_in, serial_valid,
    input  busy, match_pulse, match_count, count_sat, done
  );

  modport slave (
    input  cfg_load, cfg_pattern, start, stop, run_len, serial_in, serial_valid,
    output busy, match_pulse, match_count, count_sat, done
  );

endinterface

// File: rtl/pattern_match_ctrl_bit_window.sv
// bit_window: PAT_W-bit shift register holding the most recent serial bits.
// Ports:
//   clk, n_rst  clock and asynchronous active-low reset
//   clear_i     synchronous clear, takes priority over shifting
//   shift_i     shift bit_i in at the LSB end
//   bit_i       incoming serial bit
//   window_o    current window contents (MSB = oldest bit)
module bit_window #(
  parameter int PAT_W = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear_i,
  input  logic             shift_i,
  input  logic             bit_i,
  output logic [PAT_W-1:0] window_o
);

  logic [PAT_W-1:0] window_q;
  logic [PAT_W-1:0] window_d;

  // Clear wins so that a new run never sees bits left over from the last one.
  always_comb begin
    window_d = window_q;
    if (clear_i) begin
      window_d = '0;
    end else if (shift_i) begin
      window_d = {window_q[PAT_W-2:0], bit_i};
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      window_q <= '0;
    end else begin
      window_q <= window_d;
    end
  end

  assign window_o = window_q;

endmodule

// File: rtl/pattern_match_ctrl.sv
// pattern_match_ctrl: run controller for a programmable serial bit-pattern recognizer.
// Ports:
//   clk    rising-edge system clock
//   n_rst  asynchronous active-low reset
//   bus    slave side of pattern_match_ctrl_if (config, run control, serial data, status)
// A run is started from IDLE, primes the window during FILL, compares every accepted bit
// in RUN, and either ends after run_len bits (through DONE) or is aborted by stop.
module pattern_match_ctrl
  import pattern_ctrl_pkg::*;
#(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8,
  parameter int LEN_W = 8
) (
  input logic                 clk,
  input logic                 n_rst,
  pattern_match_ctrl_if.slave bus
);

  localparam int FILL_W = (PAT_W > 2) ? $clog2(PAT_W - 1) : 1;
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_W - 2);

  pm_state_t        state_q, state_d;
  logic [PAT_W-1:0] pattern_q, pattern_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [LEN_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [LEN_W-1:0] run_len_q, run_len_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             sat_q, sat_d;
  logic             pulse_q, pulse_d;
  logic             done_q, done_d;

  logic             win_clear;
  logic             win_shift;
  logic [PAT_W-1:0] window;
  logic [PAT_W-1:0] cand;
  logic [LEN_W-1:0] bit_next;
  logic             last_bit;
  logic             unused_oldest;

  bit_window #(.PAT_W(PAT_W)) u_window (
    .clk      (clk),
    .n_rst    (n_rst),
    .clear_i  (win_clear),
    .shift_i  (win_shift),
    .bit_i    (bus.serial_in),
    .window_o (window)
  );

  // The compare looks at the window as it will be after this bit shifts in,
  // so the oldest stored bit is about to fall off and never takes part.
  assign cand          = {window[PAT_W-2:0], bus.serial_in};
  assign unused_oldest = window[PAT_W-1];

  assign bit_next = bit_cnt_q + LEN_W'(1);
  assign last_bit = (run_len_q != '0) && (bit_next == run_len_q);

  // Next-state logic. stop is checked before serial_valid so that an abort
  // discards a bit arriving in the same cycle. The run-length check comes
  // last so it can end a run straight out of FILL.
  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    fill_d    = fill_q;
    bit_cnt_d = bit_cnt_q;
    run_len_d = run_len_q;
    count_d   = count_q;
    sat_d     = sat_q;
    pulse_d   = 1'b0;
    done_d    = 1'b0;
    win_clear = 1'b0;
    win_shift = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.cfg_load) begin
          pattern_d = bus.cfg_pattern;
        end
        if (bus.start) begin
          state_d   = FILL;
          win_clear = 1'b1;
          fill_d    = '0;
          bit_cnt_d = '0;
          count_d   = '0;
          sat_d     = 1'b0;
          run_len_d = bus.run_len;
        end
      end

      FILL, RUN: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else if (bus.serial_valid) begin
          win_shift = 1'b1;
          bit_cnt_d = bit_next;
          if (state_q == FILL) begin
            fill_d = fill_q + FILL_W'(1);
            if (fill_q == FILL_LAST) begin
              state_d = RUN;
            end
          end else if (cand == pattern_q) begin
            pulse_d = 1'b1;
            if (count_q != '1) begin
              count_d = count_q + CNT_W'(1);
            end
            if (count_d == '1) begin
              sat_d = 1'b1;
            end
          end
          if (last_bit) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // All run state and status outputs are registered here.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      pattern_q <= '0;
      fill_q    <= '0;
      bit_cnt_q <= '0;
      run_len_q <= '0;
      count_q   <= '0;
      sat_q     <= 1'b0;
      pulse_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      fill_q    <= fill_d;
      bit_cnt_q <= bit_cnt_d;
      run_len_q <= run_len_d;
      count_q   <= count_d;
      sat_q     <= sat_d;
      pulse_q   <= pulse_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy        = (state_q == FILL) || (state_q == RUN);
  assign bus.match_pulse = pulse_q;
  assign bus.match_count = count_q;
  assign bus.count_sat   = sat_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_pattern_match_ctrl.sv
// Testbench for pattern_match_ctrl: directed scenarios with hand-computed expectations.
// Inputs are driven 1 time unit after the rising edge and outputs are read at the same
// point, so every sample reflects the edge that consumed the previous inputs.
module tb_pattern_match_ctrl;

  localparam int PAT_W = 4;
  localparam int CNT_W = 8;
  localparam int LEN_W = 8;

  logic clk   = 1'b0;
  logic n_rst = 1'b0;

  int compared   = 0;
  int mismatched = 0;

  pattern_match_ctrl_if #(.PAT_W(PAT_W), .CNT_W(CNT_W), .LEN_W(LEN_W)) bus ();

  pattern_match_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W), .LEN_W(LEN_W)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic loadPattern(input logic [PAT_W-1:0] p);
    bus.cfg_load    = 1'b1;
    bus.cfg_pattern = p;
    tick();
    bus.cfg_load    = 1'b0;
  endtask

  task automatic startRun(input logic [LEN_W-1:0] len);
    bus.start   = 1'b1;
    bus.run_len = len;
    tick();
    bus.start   = 1'b0;
  endtask

  task automatic stopRun();
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
  endtask

  task automatic sendBit(input logic b);
    bus.serial_in    = b;
    bus.serial_valid = 1'b1;
    tick();
    bus.serial_valid = 1'b0;
  endtask

  // Reset state, asynchronous reset in the middle of a run, and pattern cleared by reset.
  task automatic test_reset();
    logic expP [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    n_rst = 1'b0;
    #12;
    compared++;
    if ({bus.busy, bus.match_pulse, bus.match_count, bus.count_sat, bus.done} !== '0) begin
      mismatched++;
      $display("[TB] FAIL reset_outputs: got busy=%b pulse=%b count=%0d sat=%b done=%b, expected all 0",
               bus.busy, bus.match_pulse, bus.match_count, bus.count_sat, bus.done);
    end
    @(negedge clk);
    n_rst = 1'b1;
    tick();

    loadPattern(4'b1101);
    startRun(8'd0);
    sendBit(1'b1); sendBit(1'b1); sendBit(1'b0); sendBit(1'b1);
    compared++;
    if (bus.match_count !== 8'd1 || bus.busy !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL reset_prerun: got count=%0d busy=%b, expected count=1 busy=1",
               bus.match_count, bus.busy);
    end

    #2;
    n_rst = 1'b0;
    #1;
    compared++;
    if ({bus.busy, bus.match_pulse, bus.match_count, bus.count_sat, bus.done} !== '0) begin
      mismatched++;
      $display("[TB] FAIL reset_async: got busy=%b pulse=%b count=%0d sat=%b done=%b, expected all 0",
               bus.busy, bus.match_pulse, bus.match_count, bus.count_sat, bus.done);
    end
    tick();
    tick();
    n_rst = 1'b1;
    tick();
    compared++;
    if (bus.busy !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_idle: got busy=%b expected 0", bus.busy);
    end

    // Pattern was cleared to 0000, so four zeros must match on the fourth bit.
    startRun(8'd0);
    for (int i = 0; i < 4; i++) begin
      sendBit(1'b0);
      compared++;
      if (bus.match_pulse !== expP[i]) begin
        mismatched++;
        $display("[TB] FAIL reset_pattern_cleared bit %0d: got pulse=%b expected %b",
                 i, bus.match_pulse, expP[i]);
      end
    end
    stopRun();
  endtask

  // Pattern 1101 on 1101101: overlapping matches on bits 4 and 7.
  task automatic test_overlap();
    logic bits [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic expP [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    loadPattern(4'b1101);
    startRun(8'd0);
    for (int i = 0; i < 7; i++) begin
      sendBit(bits[i]);
      compared++;
      if (bus.match_pulse !== expP[i] || bus.done !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL overlap bit %0d: got pulse=%b done=%b expected pulse=%b done=0",
                 i, bus.match_pulse, bus.done, expP[i]);
      end
    end
    compared++;
    if (bus.match_count !== 8'd2 || bus.busy !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL overlap_count: got count=%0d busy=%b expected count=2 busy=1",
               bus.match_count, bus.busy);
    end
    stopRun();
    compared++;
    if (bus.busy !== 1'b0 || bus.match_count !== 8'd2 || bus.done !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL overlap_stop: got busy=%b count=%0d done=%b expected busy=0 count=2 done=0",
               bus.busy, bus.match_count, bus.done);
    end
  endtask

  // run_len=8 with gaps in serial_valid; the eighth bit both matches and ends the run.
  // Then run_len=3, shorter than the pattern, ends the run straight out of FILL.
  task automatic test_run_len();
    logic bits [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic expP [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic expD [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    loadPattern(4'b1101);
    startRun(8'd8);
    for (int i = 0; i < 8; i++) begin
      for (int g = 0; g < (i % 3); g++) begin
        tick();
        compared++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.match_pulse !== 1'b0) begin
          mismatched++;
          $display("[TB] FAIL runlen_gap before bit %0d: got busy=%b done=%b pulse=%b expected 1/0/0",
                   i, bus.busy, bus.done, bus.match_pulse);
        end
      end
      sendBit(bits[i]);
      compared++;
      if (bus.match_pulse !== expP[i] || bus.done !== expD[i]) begin
        mismatched++;
        $display("[TB] FAIL runlen bit %0d: got pulse=%b done=%b expected pulse=%b done=%b",
                 i, bus.match_pulse, bus.done, expP[i], expD[i]);
      end
    end
    compared++;
    if (bus.busy !== 1'b0 || bus.match_count !== 8'd2) begin
      mismatched++;
      $display("[TB] FAIL runlen_end: got busy=%b count=%0d expected busy=0 count=2",
               bus.busy, bus.match_count);
    end
    tick();
    compared++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL runlen_after: got done=%b busy=%b expected done=0 busy=0",
               bus.done, bus.busy);
    end

    startRun(8'd3);
    compared++;
    if (bus.busy !== 1'b1 || bus.match_count !== 8'd0) begin
      mismatched++;
      $display("[TB] FAIL runlen_restart: got busy=%b count=%0d expected busy=1 count=0",
               bus.busy, bus.match_count);
    end
    for (int i = 0; i < 3; i++) begin
      sendBit(1'b1);
      compared++;
      if (bus.done !== (i == 2) || bus.match_pulse !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL runlen_fill bit %0d: got done=%b pulse=%b expected done=%b pulse=0",
                 i, bus.done, bus.match_pulse, (i == 2));
      end
    end
    tick();
    compared++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL runlen_fill_idle: got busy=%b done=%b expected 0/0", bus.busy, bus.done);
    end
  endtask

  // Pattern 1111 with 300 ones: 297 hits saturate the counter at 255.
  task automatic test_saturation();
    loadPattern(4'b1111);
    startRun(8'd0);
    repeat (257) sendBit(1'b1);
    compared++;
    if (bus.match_count !== 8'd254 || bus.count_sat !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL sat_before: got count=%0d sat=%b expected count=254 sat=0",
               bus.match_count, bus.count_sat);
    end
    sendBit(1'b1);
    compared++;
    if (bus.match_count !== 8'd255 || bus.count_sat !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL sat_reach: got count=%0d sat=%b expected count=255 sat=1",
               bus.match_count, bus.count_sat);
    end
    repeat (42) sendBit(1'b1);
    compared++;
    if (bus.match_count !== 8'd255 || bus.count_sat !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL sat_hold: got count=%0d sat=%b expected count=255 sat=1",
               bus.match_count, bus.count_sat);
    end
    stopRun();
    compared++;
    if (bus.match_count !== 8'd255 || bus.count_sat !== 1'b1 || bus.busy !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL sat_idle: got count=%0d sat=%b busy=%b expected 255/1/0",
               bus.match_count, bus.count_sat, bus.busy);
    end
    startRun(8'd0);
    compared++;
    if (bus.match_count !== 8'd0 || bus.count_sat !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL sat_clear: got count=%0d sat=%b expected count=0 sat=0",
               bus.match_count, bus.count_sat);
    end
    stopRun();
  endtask

  // stop arrives with the bit that would both match and end a run_len=4 run.
  task automatic test_stop_with_bit();
    loadPattern(4'b1101);
    startRun(8'd4);
    sendBit(1'b1); sendBit(1'b1); sendBit(1'b0);
    bus.stop         = 1'b1;
    bus.serial_in    = 1'b1;
    bus.serial_valid = 1'b1;
    tick();
    bus.stop         = 1'b0;
    bus.serial_valid = 1'b0;
    compared++;
    if (bus.match_pulse !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.match_count !== 8'd0) begin
      mismatched++;
      $display("[TB] FAIL stop_bit: got pulse=%b done=%b busy=%b count=%0d expected 0/0/0/0",
               bus.match_pulse, bus.done, bus.busy, bus.match_count);
    end
    tick();
    compared++;
    if (bus.match_pulse !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL stop_after: got pulse=%b done=%b busy=%b expected 0/0/0",
               bus.match_pulse, bus.done, bus.busy);
    end
  endtask

  // cfg_load of 0110 while busy is ignored; the same load together with start takes effect.
  task automatic test_cfg_busy();
    logic bitsA [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic expA  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic bitsB [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic expB  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    loadPattern(4'b1101);
    startRun(8'd0);
    bus.cfg_load    = 1'b1;
    bus.cfg_pattern = 4'b0110;
    for (int i = 0; i < 5; i++) begin
      sendBit(bitsA[i]);
      compared++;
      if (bus.match_pulse !== expA[i]) begin
        mismatched++;
        $display("[TB] FAIL cfg_busy bit %0d: got pulse=%b expected %b", i, bus.match_pulse, expA[i]);
      end
    end
    bus.cfg_load = 1'b0;
    compared++;
    if (bus.match_count !== 8'd1) begin
      mismatched++;
      $display("[TB] FAIL cfg_busy_count: got %0d expected 1", bus.match_count);
    end
    stopRun();

    bus.cfg_load    = 1'b1;
    bus.cfg_pattern = 4'b0110;
    bus.start       = 1'b1;
    bus.run_len     = 8'd0;
    tick();
    bus.cfg_load    = 1'b0;
    bus.start       = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sendBit(bitsB[i]);
      compared++;
      if (bus.match_pulse !== expB[i]) begin
        mismatched++;
        $display("[TB] FAIL cfg_idle bit %0d: got pulse=%b expected %b", i, bus.match_pulse, expB[i]);
      end
    end
    compared++;
    if (bus.match_count !== 8'd1) begin
      mismatched++;
      $display("[TB] FAIL cfg_idle_count: got %0d expected 1", bus.match_count);
    end
    stopRun();
  endtask

  initial begin
    bus.cfg_load     = 1'b0;
    bus.cfg_pattern  = '0;
    bus.start        = 1'b0;
    bus.stop         = 1'b0;
    bus.run_len      = '0;
    bus.serial_in    = 1'b0;
    bus.serial_valid = 1'b0;

    $display("[TB] starting pattern_match_ctrl bench");
    test_reset();
    test_overlap();
    test_run_len();
    test_saturation();
    test_stop_with_bit();
    test_cfg_busy();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
